// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store path: instruction classes, memory functions,
// LSU states and fault codes.
package load_store_unit_pkg;

  typedef enum logic [2:0] {
    ALU    = 3'd0,
    LOAD   = 3'd1,
    STORE  = 3'd2,
    BRANCH = 3'd3,
    JUMP   = 3'd4,
    SYSTEM = 3'd5
  } IType;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd3,
    LHU = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } MemFunc;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } LsuState;

  localparam logic [1:0] FAULT_OK       = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;

  // Access size code: 0 = byte, 1 = halfword, 2 = word.
  function automatic logic [1:0] accessSize(input MemFunc f);
    case (f)
      LB, LBU, SB: accessSize = 2'd0;
      LH, LHU, SH: accessSize = 2'd1;
      default:     accessSize = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_mem_align.sv
// Combinational lane steering: byte enables, store-data shift, misalignment
// detection and load-result extraction/extension.
module mem_align
  import load_store_unit_pkg::*;
(
  input  MemFunc      i_func,
  input  logic [1:0]  i_addrLo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misaligned
);

  logic [1:0]  w_size;
  logic [4:0]  w_shamt;
  logic [31:0] w_shifted;

  assign w_size    = accessSize(i_func);
  assign w_shamt   = {i_addrLo, 3'b000};
  assign w_shifted = i_rdata >> w_shamt;
  assign o_wdata   = i_wdata << w_shamt;

  always_comb begin
    o_be         = 4'b0000;
    o_misaligned = 1'b0;
    case (w_size)
      2'd0: o_be = 4'b0001 << i_addrLo;
      2'd1: begin
        o_be         = 4'b0011 << i_addrLo;
        o_misaligned = i_addrLo[0];
      end
      default: begin
        o_be         = 4'b1111;
        o_misaligned = |i_addrLo;
      end
    endcase
  end

  // Read data arrives as a full word; pull the addressed lanes down to bit 0.
  always_comb begin
    o_rdata = w_shifted;
    case (i_func)
      LB:      o_rdata = {{24{w_shifted[7]}}, w_shifted[7:0]};
      LH:      o_rdata = {{16{w_shifted[15]}}, w_shifted[15:0]};
      LBU:     o_rdata = {24'b0, w_shifted[7:0]};
      LHU:     o_rdata = {16'b0, w_shifted[15:0]};
      default: o_rdata = w_shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory op at a time, issues a single-cycle
// memory strobe, waits (with timeout) for completion and returns one response.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  IType        iType_in,
  input  MemFunc      memFunc_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] data_in,
  output logic        resp_valid_out,
  output logic [31:0] resp_data_out,
  output logic [1:0]  resp_fault_out,
  output logic        mem_req_out,
  output logic        mem_we_out,
  output logic [31:0] mem_addr_out,
  output logic [3:0]  mem_be_out,
  output logic [31:0] mem_wdata_out,
  input  logic        mem_rvalid_in,
  input  logic [31:0] mem_rdata_in
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

  LsuState       r_state;
  IType          r_iType;
  MemFunc        r_func;
  logic [1:0]    r_addrLo;
  logic [CW-1:0] r_waitCnt;
  logic          r_ready;
  logic          r_respValid;
  logic [31:0]   r_respData;
  logic [1:0]    r_respFault;
  logic          r_memReq;
  logic          r_memWe;
  logic [31:0]   r_memAddr;
  logic [3:0]    r_memBe;
  logic [31:0]   r_memWdata;

  MemFunc      w_alFunc;
  logic [1:0]  w_alAddrLo;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_loadData;
  logic        w_misaligned;
  logic        w_accept;
  logic        w_isMem;

  // The aligner sees the live request while idle and the latched one afterwards.
  assign w_alFunc   = (r_state == IDLE) ? memFunc_in   : r_func;
  assign w_alAddrLo = (r_state == IDLE) ? addr_in[1:0] : r_addrLo;
  assign w_accept   = req_valid_in && r_ready;
  assign w_isMem    = (iType_in == LOAD) || (iType_in == STORE);

  mem_align u_memAlign (
    .i_func       (w_alFunc),
    .i_addrLo     (w_alAddrLo),
    .i_wdata      (data_in),
    .i_rdata      (mem_rdata_in),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_rdata      (w_loadData),
    .o_misaligned (w_misaligned)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= IDLE;
      r_iType     <= ALU;
      r_func      <= LB;
      r_addrLo    <= 2'b00;
      r_waitCnt   <= '0;
      r_ready     <= 1'b0;
      r_respValid <= 1'b0;
      r_respData  <= '0;
      r_respFault <= FAULT_OK;
      r_memReq    <= 1'b0;
      r_memWe     <= 1'b0;
      r_memAddr   <= '0;
      r_memBe     <= '0;
      r_memWdata  <= '0;
    end else begin
      r_memReq    <= 1'b0;
      r_respValid <= 1'b0;
      r_ready     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_iType   <= iType_in;
            r_func    <= memFunc_in;
            r_addrLo  <= addr_in[1:0];
            r_waitCnt <= '0;
            if (!w_isMem || w_misaligned) begin
              r_state     <= RESP;
              r_respValid <= 1'b1;
              r_respData  <= '0;
              r_respFault <= w_isMem ? FAULT_MISALIGN : FAULT_OK;
            end else begin
              r_state    <= ISSUE;
              r_memReq   <= 1'b1;
              r_memWe    <= (iType_in == STORE);
              r_memAddr  <= {addr_in[31:2], 2'b00};
              r_memBe    <= w_be;
              r_memWdata <= w_wdata;
            end
          end else begin
            r_ready <= 1'b1;
          end
        end
        ISSUE: r_state <= WAIT;
        WAIT: begin
          // A completion on the final counted cycle still wins over the timeout.
          if (mem_rvalid_in) begin
            r_state     <= RESP;
            r_respValid <= 1'b1;
            r_respData  <= (r_iType == LOAD) ? w_loadData : '0;
            r_respFault <= FAULT_OK;
          end else if (r_waitCnt == LAST_WAIT) begin
            r_state     <= RESP;
            r_respValid <= 1'b1;
            r_respData  <= '0;
            r_respFault <= FAULT_TIMEOUT;
          end else begin
            r_waitCnt <= r_waitCnt + CW'(1);
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready_out  = r_ready;
  assign resp_valid_out = r_respValid;
  assign resp_data_out  = r_respData;
  assign resp_fault_out = r_respFault;
  assign mem_req_out    = r_memReq;
  assign mem_we_out     = r_memWe;
  assign mem_addr_out   = r_memAddr;
  assign mem_be_out     = r_memBe;
  assign mem_wdata_out  = r_memWdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed corner cases followed by random traffic,
// compared against a byte-lane reference model.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid;
  logic        reqReady;
  IType        iType;
  MemFunc      memFunc;
  logic [31:0] addr;
  logic [31:0] data;
  logic        respValid;
  logic [31:0] respData;
  logic [1:0]  respFault;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [3:0]  memBe;
  logic [31:0] memWdata;
  logic        memRvalid;
  logic [31:0] memRdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .req_valid_in   (reqValid),
    .req_ready_out  (reqReady),
    .iType_in       (iType),
    .memFunc_in     (memFunc),
    .addr_in        (addr),
    .data_in        (data),
    .resp_valid_out (respValid),
    .resp_data_out  (respData),
    .resp_fault_out (respFault),
    .mem_req_out    (memReq),
    .mem_we_out     (memWe),
    .mem_addr_out   (memAddr),
    .mem_be_out     (memBe),
    .mem_wdata_out  (memWdata),
    .mem_rvalid_in  (memRvalid),
    .mem_rdata_in   (memRdata)
  );

  initial begin
    #400000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: accesses described as a run of n bytes starting at lane off.
  function automatic int nBytes(input MemFunc f);
    if (f == LB || f == LBU || f == SB) return 1;
    if (f == LH || f == LHU || f == SH) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] modelBe(input MemFunc f, input int off);
    logic [3:0] be;
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + nBytes(f));
    return be;
  endfunction

  function automatic logic [31:0] modelLoad(input MemFunc f, input int off, input logic [31:0] rdata);
    logic [31:0] v;
    int n;
    logic fill;
    n = nBytes(f);
    v = rdata >> (8 * off);
    if (n == 4) return v;
    fill = (f == LB || f == LH) ? v[8 * n - 1] : 1'b0;
    for (int i = 8 * n; i < 32; i++) v[i] = fill;
    return v;
  endfunction

  // delay = WAIT cycle index at which completion arrives; negative means never.
  task automatic applyStimulus(input string name, input IType it, input MemFunc f,
                               input logic [31:0] a, input logic [31:0] d,
                               input int delay, input logic [31:0] rdata);
    int off;
    int guard;
    int cycles;
    int expWaits;
    bit isMem;
    bit mis;
    bit got;
    logic [31:0] expData;
    logic [1:0]  expFault;

    off   = int'(a[1:0]);
    isMem = (it == LOAD) || (it == STORE);
    mis   = isMem && ((off % nBytes(f)) != 0);

    guard = 0;
    while (!reqReady && guard < 40) begin
      step();
      guard++;
    end
    checkOutput({name, "_readyBefore"}, 32'(reqReady), 32'd1);

    reqValid = 1'b1;
    iType    = it;
    memFunc  = f;
    addr     = a;
    data     = d;
    step();
    reqValid = 1'b0;
    iType    = IType'($urandom_range(0, 5));
    memFunc  = MemFunc'($urandom_range(0, 7));
    addr     = $urandom;
    data     = $urandom;

    if (!isMem || mis) begin
      expData  = '0;
      expFault = mis ? FAULT_MISALIGN : FAULT_OK;
      checkOutput({name, "_respValidN1"}, 32'(respValid), 32'd1);
      checkOutput({name, "_noMemReq"}, 32'(memReq), 32'd0);
    end else begin
      checkOutput({name, "_memReq"}, 32'(memReq), 32'd1);
      checkOutput({name, "_memAddr"}, memAddr, {a[31:2], 2'b00});
      checkOutput({name, "_memWe"}, 32'(memWe), 32'(it == STORE));
      checkOutput({name, "_memBe"}, 32'(memBe), 32'(modelBe(f, off)));
      if (it == STORE) checkOutput({name, "_memWdata"}, memWdata, d << (8 * off));
      step();
      checkOutput({name, "_memReqPulse"}, 32'(memReq), 32'd0);
      cycles = 0;
      got    = 1'b0;
      while (!got && cycles < 40) begin
        memRvalid = (cycles == delay);
        memRdata  = (cycles == delay) ? rdata : $urandom;
        step();
        memRvalid = 1'b0;
        cycles++;
        got = respValid;
      end
      expWaits = (delay >= 0 && delay < 16) ? delay + 1 : 16;
      checkOutput({name, "_waitCycles"}, 32'(cycles), 32'(expWaits));
      checkOutput({name, "_respValid"}, 32'(respValid), 32'd1);
      if (expWaits == 16 && !(delay == 15)) begin
        expFault = FAULT_TIMEOUT;
        expData  = '0;
      end else begin
        expFault = FAULT_OK;
        expData  = (it == LOAD) ? modelLoad(f, off, rdata) : 32'd0;
      end
    end
    checkOutput({name, "_respFault"}, 32'(respFault), 32'(expFault));
    checkOutput({name, "_respData"}, respData, expData);

    step();
    checkOutput({name, "_respPulse"}, 32'(respValid), 32'd0);
    checkOutput({name, "_readyAfter"}, 32'(reqReady), 32'd1);
    checkOutput({name, "_respHeld"}, respData, expData);
  endtask

  initial begin
    IType   rIt;
    MemFunc rF;
    int     rDelay;

    rst       = 1'b1;
    reqValid  = 1'b0;
    iType     = ALU;
    memFunc   = LB;
    addr      = '0;
    data      = '0;
    memRvalid = 1'b0;
    memRdata  = '0;
    step();
    step();
    checkOutput("rst_ready", 32'(reqReady), 32'd0);
    checkOutput("rst_respValid", 32'(respValid), 32'd0);
    checkOutput("rst_respData", respData, 32'd0);
    checkOutput("rst_memReq", 32'(memReq), 32'd0);
    checkOutput("rst_memBe", 32'(memBe), 32'd0);
    rst = 1'b0;
    step();
    checkOutput("rstRelease_ready", 32'(reqReady), 32'd1);

    applyStimulus("swBasic", STORE, SW, 32'h0000_0100, 32'hDEAD_BEEF, 0, 32'h0);
    applyStimulus("lbSigned", LOAD, LB, 32'h0000_0203, 32'h0, 0, 32'h80FF_FFFF);
    applyStimulus("lbuZero", LOAD, LBU, 32'h0000_0203, 32'h0, 0, 32'h80FF_FFFF);
    applyStimulus("shUpper", STORE, SH, 32'h0000_0102, 32'h0000_1234, 2, 32'h0);
    applyStimulus("lwMisalign", LOAD, LW, 32'h0000_0101, 32'h0, 0, 32'h0);
    applyStimulus("lwTimeout", LOAD, LW, 32'h0000_0400, 32'h0, -1, 32'h1234_5678);
    applyStimulus("lwLastCycle", LOAD, LW, 32'h0000_0404, 32'h0, 15, 32'hCAFE_F00D);
    applyStimulus("lhSigned", LOAD, LH, 32'h0000_0502, 32'h0, 3, 32'hBEEF_0000);
    applyStimulus("aluNoMem", ALU, LW, 32'h0000_0001, 32'h0, 0, 32'h0);

    // Completion strobe while idle must not produce a response.
    memRvalid = 1'b1;
    step();
    memRvalid = 1'b0;
    checkOutput("strayIdle_respValid", 32'(respValid), 32'd0);

    // Reset while waiting abandons the access.
    guard_wait: begin
      reqValid = 1'b1;
      iType    = LOAD;
      memFunc  = LW;
      addr     = 32'h0000_0600;
      step();
      reqValid = 1'b0;
      step();
      step();
      step();
      rst = 1'b1;
      step();
      checkOutput("midRst_ready", 32'(reqReady), 32'd0);
      checkOutput("midRst_respValid", 32'(respValid), 32'd0);
      rst       = 1'b0;
      memRvalid = 1'b1;
      memRdata  = 32'h5555_AAAA;
      step();
      memRvalid = 1'b0;
      checkOutput("midRst_strayResp", 32'(respValid), 32'd0);
      step();
      checkOutput("midRst_strayResp2", 32'(respValid), 32'd0);
    end
    applyStimulus("afterRst", LOAD, LHU, 32'h0000_0702, 32'h0, 1, 32'h9876_0000);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0:       rIt = BRANCH;
        1, 2, 3, 4: rIt = LOAD;
        default: rIt = STORE;
      endcase
      if (rIt == LOAD)       rF = MemFunc'($urandom_range(0, 4));
      else if (rIt == STORE) rF = MemFunc'($urandom_range(5, 7));
      else                   rF = MemFunc'($urandom_range(0, 7));
      rDelay = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5));
      applyStimulus($sformatf("rand%0d", i), rIt, rF, $urandom, $urandom, rDelay, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
